// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one data-memory port between the IFU (read-only) and
//               the LSU (read/write). LSU has priority with a bounded run.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MAX_LSU_RUN = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_stall,

    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_stall,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] c_MAX_RUN = 4'(MAX_LSU_RUN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_own;
    logic [3:0]            r_run_cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_ifu_rdata;
    logic [DATA_W-1:0]     r_lsu_rdata;
    logic                  r_ifu_resp_valid;
    logic                  r_lsu_resp_valid;

    logic                  w_lsu_win;
    logic                  w_ifu_win;
    logic                  w_resp_take;

    // The IFU only overtakes a waiting LSU once the LSU has used its full run.
    always_comb begin
        w_state_nxt = r_state;
        w_lsu_win   = 1'b0;
        w_ifu_win   = 1'b0;
        w_resp_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_lsu_win = lsu_req && !(ifu_req && (r_run_cnt == c_MAX_RUN));
                w_ifu_win = ifu_req && !w_lsu_win;
                if (w_lsu_win || w_ifu_win) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_resp_take = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_own            <= 1'b0;
            r_run_cnt        <= 4'd0;
            r_we             <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_wmask          <= '0;
            r_ifu_rdata      <= '0;
            r_lsu_rdata      <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            if (w_lsu_win) begin
                r_own   <= 1'b1;
                r_we    <= lsu_we;
                r_addr  <= lsu_addr;
                r_wdata <= lsu_wdata;
                r_wmask <= lsu_we ? lsu_wmask : '0;
                if (!ifu_req) begin
                    r_run_cnt <= 4'd0;
                end else if (r_run_cnt < c_MAX_RUN) begin
                    r_run_cnt <= r_run_cnt + 4'd1;
                end
            end else if (w_ifu_win) begin
                r_own     <= 1'b0;
                r_we      <= 1'b0;
                r_addr    <= ifu_addr;
                r_wdata   <= '0;
                r_wmask   <= '0;
                r_run_cnt <= 4'd0;
            end
            // Response is delivered to whoever owned the transaction, even if it dropped req.
            if (w_resp_take) begin
                if (r_own) begin
                    r_lsu_rdata      <= mem_rdata;
                    r_lsu_resp_valid <= 1'b1;
                end else begin
                    r_ifu_rdata      <= mem_rdata;
                    r_ifu_resp_valid <= 1'b1;
                end
            end
        end
    end

    assign mem_req_valid  = (r_state == S_ISSUE);
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;

    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_rdata      = r_ifu_rdata;
    assign ifu_stall      = ifu_req && !r_ifu_resp_valid;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_rdata      = r_lsu_rdata;
    assign lsu_stall      = lsu_req && !r_lsu_resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: vector table, directed
//               corner sequences and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MAXR = 4;

    localparam logic [63:0] Z    = 64'd0;
    localparam logic [63:0] A_I  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A_I2 = 64'h0000_0000_8000_2000;
    localparam logic [63:0] A_L  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] WL   = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] D1   = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D2   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DL   = 64'h0000_0000_0000_0055;
    localparam logic [63:0] DI   = 64'h0000_0000_0000_0077;
    localparam logic [63:0] J    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        ifu_req, ifu_resp_valid, ifu_stall;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_we, lsu_resp_valid, lsu_stall;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LSU_RUN(MAXR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata), .ifu_stall(ifu_stall),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .lsu_stall(lsu_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic ireq; logic [63:0] iaddr;
        logic lreq; logic lwe; logic [63:0] laddr; logic [63:0] lwd; logic [7:0] lwm;
        logic rdy; logic rsp; logic [63:0] rdat;
        logic ev; logic ewe; logic [63:0] eaddr; logic [63:0] ewd; logic [7:0] ewm;
        logic eirv; logic elrv; logic eist; logic elst; logic [63:0] eird; logic [63:0] elrd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req = 1'b0; ifu_addr = Z;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = Z; lsu_wdata = Z; lsu_wmask = 8'h00;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = Z;
    endtask

    task automatic chk_zero(input int idx);
        chk("rst_valid", idx, mem_req_valid, 1'b0);
        chk("rst_we", idx, mem_we, 1'b0);
        chk("rst_addr", idx, mem_addr, Z);
        chk("rst_wdata", idx, mem_wdata, Z);
        chk("rst_wmask", idx, mem_wmask, 8'h00);
        chk("rst_irv", idx, ifu_resp_valid, 1'b0);
        chk("rst_lrv", idx, lsu_resp_valid, 1'b0);
        chk("rst_ird", idx, ifu_rdata, Z);
        chk("rst_lrd", idx, lsu_rdata, Z);
    endtask

    // Reference model state: one transaction at a time, described by fields.
    bit          m_busy, m_acc, m_own, m_we, m_pi, m_pl, n_pi, n_pl;
    logic [63:0] m_addr, m_wd, m_ird, m_lrd;
    logic [7:0]  m_wm;
    int          m_streak, mem_cnt;

    initial begin
        int grants[$];
        bit pend;
        int drain;

        clear_inputs();
        ARESETn = 1'b0;
        repeat (3) tick();
        chk_zero(0);
        ARESETn = 1'b1;

        // Directed vectors: single fetch, back-to-back regrant, spurious response, LSU priority.
        tbl.push_back(vec_t'{1'b1, A_I,  1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, Z,  Z});
        tbl.push_back(vec_t'{1'b1, A_I,  1'b0, 1'b0, Z,   Z,  8'h00, 1'b1, 1'b0, Z,  1'b1, 1'b0, A_I,  Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, Z,  Z});
        tbl.push_back(vec_t'{1'b1, A_I,  1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, Z,  Z});
        tbl.push_back(vec_t'{1'b1, A_I,  1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b1, D1, 1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, Z,  Z});
        tbl.push_back(vec_t'{1'b1, A_I,  1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, D1, Z});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b1, 1'b0, Z,  1'b1, 1'b0, A_I,  Z,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, D1, Z});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b1, D2, 1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, D1, Z});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, D2, Z});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b1, J,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, D2, Z});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b1, J,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, D2, Z});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b1, 1'b1, A_L, WL, 8'h0F, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, D2, Z});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b1, 1'b1, A_L, WL, 8'h0F, 1'b1, 1'b0, Z,  1'b1, 1'b1, A_L,  WL, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, D2, Z});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b1, 1'b1, A_L, WL, 8'h0F, 1'b0, 1'b1, DL, 1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, D2, Z});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, D2, DL});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b0, 1'b0, Z,   Z,  8'h00, 1'b1, 1'b0, Z,  1'b1, 1'b0, A_I2, Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, D2, DL});
        tbl.push_back(vec_t'{1'b1, A_I2, 1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b1, DI, 1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, D2, DL});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DI, DL});
        tbl.push_back(vec_t'{1'b0, Z,    1'b0, 1'b0, Z,   Z,  8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z,    Z,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, DI, DL});

        foreach (tbl[i]) begin
            tick();
            ifu_req = tbl[i].ireq; ifu_addr = tbl[i].iaddr;
            lsu_req = tbl[i].lreq; lsu_we = tbl[i].lwe; lsu_addr = tbl[i].laddr;
            lsu_wdata = tbl[i].lwd; lsu_wmask = tbl[i].lwm;
            mem_req_ready = tbl[i].rdy; mem_resp_valid = tbl[i].rsp; mem_rdata = tbl[i].rdat;
            #1;
            chk("tbl_valid", i, mem_req_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_addr", i, mem_addr, tbl[i].eaddr);
                chk("tbl_we", i, mem_we, tbl[i].ewe);
                chk("tbl_wmask", i, mem_wmask, tbl[i].ewm);
                if (tbl[i].ewe) chk("tbl_wdata", i, mem_wdata, tbl[i].ewd);
            end
            chk("tbl_irv", i, ifu_resp_valid, tbl[i].eirv);
            chk("tbl_lrv", i, lsu_resp_valid, tbl[i].elrv);
            chk("tbl_istall", i, ifu_stall, tbl[i].eist);
            chk("tbl_lstall", i, lsu_stall, tbl[i].elst);
            chk("tbl_ird", i, ifu_rdata, tbl[i].eird);
            chk("tbl_lrd", i, lsu_rdata, tbl[i].elrd);
        end

        // Memory stalls the request for five cycles; fields must hold.
        tick();
        clear_inputs();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_3000;
        lsu_wdata = 64'h0123_4567_89AB_CDEF; lsu_wmask = 8'hF0;
        #1;
        chk("hold_grant", 0, mem_req_valid, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            chk("hold_valid", k, mem_req_valid, 1'b1);
            chk("hold_addr", k, mem_addr, 64'h8000_3000);
            chk("hold_wdata", k, mem_wdata, 64'h0123_4567_89AB_CDEF);
            chk("hold_wmask", k, mem_wmask, 8'hF0);
        end
        tick(); mem_req_ready = 1'b1; #1;
        chk("hold_hs", 6, mem_req_valid, 1'b1);
        tick(); mem_req_ready = 1'b0; #1;
        chk("hold_wait", 7, mem_req_valid, 1'b0);
        tick(); mem_resp_valid = 1'b1; mem_rdata = 64'hABCD; #1;
        tick(); mem_resp_valid = 1'b0; lsu_req = 1'b0; #1;
        chk("hold_lrv", 9, lsu_resp_valid, 1'b1);
        chk("hold_lrd", 9, lsu_rdata, 64'hABCD);

        // Both requesting continuously: four LSU grants, then one IFU grant, repeating.
        clear_inputs();
        pend = 1'b0;
        drain = 0;
        for (int c = 0; c < 300 && drain < 6; c++) begin
            tick();
            if (grants.size() < 10) begin
                ifu_req = 1'b1; ifu_addr = 64'h1000;
                lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h2000;
            end else begin
                ifu_req = 1'b0; lsu_req = 1'b0;
                drain++;
            end
            mem_req_ready = 1'b1;
            mem_resp_valid = pend;
            mem_rdata = 64'(c);
            pend = 1'b0;
            #1;
            if (mem_req_valid) begin
                grants.push_back(mem_addr == 64'h2000 ? 1 : 0);
                pend = 1'b1;
            end
        end
        chk("run_count", 0, 64'(grants.size()), 64'd10);
        for (int g = 0; g < grants.size() && g < 10; g++) begin
            chk("run_owner", g, 64'(grants[g]), ((g % 5) == 4) ? 64'd0 : 64'd1);
        end

        // Reset while waiting for the response discards the transaction.
        clear_inputs();
        tick(); lsu_req = 1'b1; lsu_addr = 64'h8000_5000; #1;
        tick(); mem_req_ready = 1'b1; #1;
        chk("arst_issue", 0, mem_req_valid, 1'b1);
        tick(); mem_req_ready = 1'b0; #1;
        chk("arst_wait", 0, mem_req_valid, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk_zero(1);
        tick(); lsu_req = 1'b0; #1;
        chk_zero(2);
        tick(); ARESETn = 1'b1; #1;
        tick(); mem_resp_valid = 1'b1; mem_rdata = J; #1;
        chk("arst_idle", 0, mem_req_valid, 1'b0);
        tick(); mem_resp_valid = 1'b0; #1;
        chk("arst_lrv", 0, lsu_resp_valid, 1'b0);
        chk("arst_irv", 0, ifu_resp_valid, 1'b0);
        chk("arst_lrd", 0, lsu_rdata, Z);
        chk("arst_idle2", 0, mem_req_valid, 1'b0);

        // Randomized traffic against the reference model.
        clear_inputs();
        m_busy = 1'b0; m_acc = 1'b0; m_own = 1'b0; m_we = 1'b0; m_pi = 1'b0; m_pl = 1'b0;
        m_addr = Z; m_wd = Z; m_wm = 8'h00; m_ird = Z; m_lrd = Z; m_streak = 0; mem_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!ifu_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    ifu_req = 1'b1; ifu_addr = {$urandom, $urandom};
                end
            end else if (m_pi) begin
                if ($urandom_range(1, 0) == 1) ifu_req = 1'b0;
                else ifu_addr = {$urandom, $urandom};
            end else if ($urandom_range(15, 0) == 0) begin
                ifu_req = 1'b0;
            end
            if (!lsu_req || m_pl) begin
                lsu_req = ($urandom_range(3, 0) != 0);
                lsu_we = 1'($urandom_range(1, 0));
                lsu_addr = {$urandom, $urandom};
                lsu_wdata = {$urandom, $urandom};
                lsu_wmask = 8'($urandom_range(255, 0));
            end else if ($urandom_range(15, 0) == 0) begin
                lsu_req = 1'b0;
            end
            mem_req_ready = 1'($urandom_range(1, 0));
            mem_resp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_resp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
                end
            end else if ($urandom_range(7, 0) == 0) begin
                mem_resp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
            end
            #1;
            chk("rnd_valid", n, mem_req_valid, m_busy && !m_acc);
            if (m_busy && !m_acc) begin
                chk("rnd_addr", n, mem_addr, m_addr);
                chk("rnd_we", n, mem_we, m_we);
                chk("rnd_wmask", n, mem_wmask, m_wm);
                if (m_we) chk("rnd_wdata", n, mem_wdata, m_wd);
            end
            chk("rnd_irv", n, ifu_resp_valid, m_pi);
            chk("rnd_lrv", n, lsu_resp_valid, m_pl);
            chk("rnd_ird", n, ifu_rdata, m_ird);
            chk("rnd_lrd", n, lsu_rdata, m_lrd);
            chk("rnd_istall", n, ifu_stall, ifu_req && !m_pi);
            chk("rnd_lstall", n, lsu_stall, lsu_req && !m_pl);

            n_pi = 1'b0; n_pl = 1'b0;
            if (!m_busy) begin
                if (lsu_req && !(ifu_req && m_streak == MAXR)) begin
                    m_busy = 1'b1; m_acc = 1'b0; m_own = 1'b1; m_we = lsu_we;
                    m_addr = lsu_addr; m_wd = lsu_wdata; m_wm = lsu_we ? lsu_wmask : 8'h00;
                    m_streak = ifu_req ? m_streak + 1 : 0;
                end else if (ifu_req) begin
                    m_busy = 1'b1; m_acc = 1'b0; m_own = 1'b0; m_we = 1'b0;
                    m_addr = ifu_addr; m_wm = 8'h00;
                    m_streak = 0;
                end
            end else if (!m_acc) begin
                if (mem_req_ready) begin
                    m_acc = 1'b1;
                    mem_cnt = $urandom_range(3, 1);
                end
            end else if (mem_resp_valid) begin
                m_busy = 1'b0; m_acc = 1'b0;
                if (m_own) begin m_lrd = mem_rdata; n_pl = 1'b1; end
                else begin m_ird = mem_rdata; n_pi = 1'b1; end
            end
            m_pi = n_pi; m_pl = n_pl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
